// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the shared 8-bit external memory port.
// Each access is an address/strobe phase of WAIT_CYCLES+1 cycles followed by a one-cycle ack.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       we0,
    input  logic [7:0] addr0,
    input  logic [7:0] wdata0,
    output logic       ack0,
    input  logic       req1,
    input  logic       we1,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata1,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_read,
    output logic       mem_write,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       owner
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       rr_last;
    logic       win;
    logic       win_we;

    // With both requesting, the port that did not win last time is granted.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = ~rr_last;
        end else begin
            win = req1;
        end
        win_we = win ? we1 : we0;
    end

    // The strobes themselves carry the latched we during ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rr_last   <= 1'b1;
            owner     <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            busy      <= 1'b0;
            rdata     <= 8'd0;
            mem_addr  <= 8'd0;
            mem_wdata <= 8'd0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (req0 || req1) begin
                        state     <= ACCESS;
                        cnt       <= WAIT_LD;
                        owner     <= win;
                        rr_last   <= win;
                        busy      <= 1'b1;
                        mem_addr  <= win ? addr1 : addr0;
                        mem_read  <= ~win_we;
                        mem_write <= win_we;
                        if (win_we) begin
                            mem_wdata <= win ? wdata1 : wdata0;
                        end else begin
                            mem_wdata <= 8'd0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (mem_read) begin
                            rdata <= mem_rdata;
                        end
                        state     <= DONE;
                        ack0      <= ~owner;
                        ack1      <= owner;
                        mem_addr  <= 8'd0;
                        mem_wdata <= 8'd0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a uses WAIT_CYCLES=1, instance b WAIT_CYCLES=0.
// External memory model returns addr ^ 8'h48.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    logic       a_req0 = 0, a_we0 = 0, a_req1 = 0, a_we1 = 0;
    logic [7:0] a_addr0 = 0, a_wdata0 = 0, a_addr1 = 0, a_wdata1 = 0;
    logic       a_ack0, a_ack1, a_mem_read, a_mem_write, a_busy, a_owner;
    logic [7:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic       b_req0 = 0, b_we0 = 0, b_req1 = 0, b_we1 = 0;
    logic [7:0] b_addr0 = 0, b_wdata0 = 0, b_addr1 = 0, b_wdata1 = 0;
    logic       b_ack0, b_ack1, b_mem_read, b_mem_write, b_busy, b_owner;
    logic [7:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    assign a_mem_rdata = a_mem_addr ^ 8'h48;
    assign b_mem_rdata = b_mem_addr ^ 8'h48;

    mem_port_arbiter #(.WAIT_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req0(a_req0), .we0(a_we0), .addr0(a_addr0), .wdata0(a_wdata0), .ack0(a_ack0),
        .req1(a_req1), .we1(a_we1), .addr1(a_addr1), .wdata1(a_wdata1), .ack1(a_ack1),
        .rdata(a_rdata), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_rdata(a_mem_rdata),
        .busy(a_busy), .owner(a_owner)
    );

    mem_port_arbiter #(.WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1),
        .rdata(b_rdata), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_rdata(b_mem_rdata),
        .busy(b_busy), .owner(b_owner)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        chk("rst_ack0", a_ack0, 0);
        chk("rst_ack1", a_ack1, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_owner", a_owner, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_mrd", a_mem_read, 0);
        chk("rst_mwr", a_mem_write, 0);
        chk("rst_maddr", a_mem_addr, 0);
        rst_n = 1'b1;
        step();

        // port 0 read of 0x12
        a_req0 = 1; a_we0 = 0; a_addr0 = 8'h12;
        step();
        chk("rd_c1_mrd", a_mem_read, 1);
        chk("rd_c1_addr", a_mem_addr, 8'h12);
        chk("rd_c1_busy", a_busy, 1);
        chk("rd_c1_ack0", a_ack0, 0);
        step();
        chk("rd_c2_mrd", a_mem_read, 1);
        chk("rd_c2_addr", a_mem_addr, 8'h12);
        step();
        chk("rd_d_mrd", a_mem_read, 0);
        chk("rd_d_addr", a_mem_addr, 0);
        chk("rd_d_ack0", a_ack0, 1);
        chk("rd_d_ack1", a_ack1, 0);
        chk("rd_d_rdata", a_rdata, 8'h5A);
        chk("rd_d_busy", a_busy, 1);
        a_req0 = 0;
        step();
        chk("rd_i_ack0", a_ack0, 0);
        chk("rd_i_busy", a_busy, 0);

        // port 1 write 0xC3 to 0x40
        a_req1 = 1; a_we1 = 1; a_addr1 = 8'h40; a_wdata1 = 8'hC3;
        step();
        for (int i = 0; i < 2; i++) begin
            chk("wr_mwr", a_mem_write, 1);
            chk("wr_mrd", a_mem_read, 0);
            chk("wr_addr", a_mem_addr, 8'h40);
            chk("wr_wdata", a_mem_wdata, 8'hC3);
            chk("wr_owner", a_owner, 1);
            step();
        end
        chk("wr_d_mwr", a_mem_write, 0);
        chk("wr_d_wdata", a_mem_wdata, 0);
        chk("wr_d_ack1", a_ack1, 1);
        chk("wr_d_ack0", a_ack0, 0);
        chk("wr_d_rdata", a_rdata, 8'h5A);
        a_req1 = 0; a_we1 = 0;
        step();

        // both requesting from reset: grants 0,1,0,1 every 4 cycles
        rst_n = 0;
        step();
        rst_n = 1;
        a_req0 = 1; a_addr0 = 8'h20;
        a_req1 = 1; a_addr1 = 8'h30;
        for (int i = 0; i < 16; i++) begin
            automatic int n = i / 4;
            automatic logic p = 1'(n % 2);
            step();
            case (i % 4)
                0, 1: begin
                    chk("rr_owner", a_owner, p);
                    chk("rr_mrd", a_mem_read, 1);
                    chk("rr_addr", a_mem_addr, p ? 8'h30 : 8'h20);
                end
                2: begin
                    chk("rr_ack0", a_ack0, !p);
                    chk("rr_ack1", a_ack1, p);
                    chk("rr_d_mrd", a_mem_read, 0);
                    chk("rr_d_addr", a_mem_addr, 0);
                    chk("rr_d_rdata", a_rdata, p ? 8'h78 : 8'h68);
                end
                default: begin
                    chk("rr_i_busy", a_busy, 0);
                end
            endcase
        end
        a_req0 = 0; a_req1 = 0;
        step();
        chk("rr_end_busy", a_busy, 0);

        // reset during a port 1 read
        a_req1 = 1; a_addr1 = 8'h33;
        step();
        chk("rs_owner", a_owner, 1);
        chk("rs_mrd", a_mem_read, 1);
        #2 rst_n = 0;
        #1;
        chk("rs_async_mrd", a_mem_read, 0);
        chk("rs_async_busy", a_busy, 0);
        a_req1 = 0;
        step();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rs_no_ack1", a_ack1, 0);
        end

        // after release, port 0 wins the tie; req0 dropped right after grant
        a_req0 = 1; a_req1 = 1; a_addr0 = 8'h55; a_addr1 = 8'h66;
        step();
        chk("tie_owner", a_owner, 0);
        chk("tie_addr", a_mem_addr, 8'h55);
        a_req0 = 0; a_req1 = 0; a_addr0 = 8'hFF;
        step();
        chk("drop_addr", a_mem_addr, 8'h55);
        step();
        chk("drop_ack0", a_ack0, 1);
        chk("drop_rdata", a_rdata, 8'h1D);
        step();
        chk("drop_i_busy", a_busy, 0);
        step();
        chk("drop_nogrant", a_busy, 0);
        chk("drop_nomrd", a_mem_read, 0);

        // WAIT_CYCLES=0 back-to-back reads
        b_req0 = 1; b_addr0 = 8'h01;
        step();
        chk("w0_c1_mrd", b_mem_read, 1);
        chk("w0_c1_addr", b_mem_addr, 8'h01);
        step();
        chk("w0_c2_mrd", b_mem_read, 0);
        chk("w0_c2_ack0", b_ack0, 1);
        chk("w0_c2_rdata", b_rdata, 8'h49);
        b_addr0 = 8'h02;
        step();
        chk("w0_c3_ack0", b_ack0, 0);
        step();
        chk("w0_c4_mrd", b_mem_read, 1);
        chk("w0_c4_addr", b_mem_addr, 8'h02);
        b_req0 = 0;
        step();
        chk("w0_c5_ack0", b_ack0, 1);
        chk("w0_c5_rdata", b_rdata, 8'h4A);
        chk("w0_c5_ack1", b_ack1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
